cont_int_pulse_sequencer: RTL and testbench

- Avalon-MM slave that owns the 6 control/interrupt output lines of the main PLD.
- Combines a CPU-written static level register with hardware-timed one-shot pulses. Firmware writes a line mask, and the block pulses each selected line in ascending order with a programmable width and gap.
- Raises irq when the sequence completes, so firmware no longer bit-bangs pulse timing.

---
 rtl/cont_int_pulse_sequencer_if.sv | 20 ++
 rtl/cont_int_pulse_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cont_int_pulse_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cont_int_pulse_sequencer_if.sv
// Avalon-MM slave bus bundle for the control/interrupt pulse sequencer.
// Reads return one clock after the strobe; the slave never stalls (no waitrequest).
interface cont_int_pulse_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );
endinterface

// File: rtl/cont_int_pulse_sequencer.sv
// Control-line driver: static LEVEL OR'd with hardware-timed one-shot pulses, irq on completion.
// out_port/irq/readdata are registered (1 clock); the bus never stalls, and a PULSE write while busy is dropped and flagged.
module cont_int_pulse_sequencer #(
  parameter int NUM_LINES = 6,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  cont_int_pulse_sequencer_if.slave bus,
  output logic [NUM_LINES-1:0]     out_port,
  output logic                     irq
);

  typedef enum logic [1:0] {IDLE, SCAN, PULSE, GAP} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] level_q;
  logic [NUM_LINES-1:0] pulse_vec;
  logic [NUM_LINES-1:0] pending;
  logic [CNT_W-1:0]     width_q;
  logic [CNT_W-1:0]     gap_q;
  logic [CNT_W-1:0]     prescale_q;
  logic [CNT_W-1:0]     pre_cnt;
  logic [CNT_W-1:0]     pre_val;
  logic [CNT_W-1:0]     phase_cnt;
  logic                 done;
  logic                 overrun;
  logic                 irq_en;

  logic                 wr;
  logic                 rd;
  logic                 wr_pulse;
  logic                 wr_status;
  logic                 abort;
  logic                 tick_end;
  logic                 phase_last;
  logic                 done_set;
  logic                 done_clr;
  logic [NUM_LINES-1:0] mask;
  logic [NUM_LINES-1:0] low_oh;
  logic [NUM_LINES-1:0] pulse_nxt;
  logic [NUM_LINES-1:0] level_nxt;
  logic [31:0]          rd_mux;
  logic                 unused_wd;

  assign wr         = bus.chipselect & ~bus.write_n;
  assign rd         = bus.chipselect & ~bus.read_n;
  assign mask       = bus.writedata[NUM_LINES-1:0];
  assign wr_pulse   = wr && (bus.address == 3'd1);
  assign wr_status  = wr && (bus.address == 3'd5);
  assign abort      = wr_status && bus.writedata[3] && (state != IDLE);
  assign low_oh     = pending & (~pending + NUM_LINES'(1));
  assign tick_end   = (pre_cnt == '0);
  assign phase_last = tick_end && (phase_cnt == CNT_W'(1));
  assign done_clr   = wr_status && bus.writedata[1];
  assign level_nxt  = (wr && bus.address == 3'd0) ? mask : level_q;
  assign unused_wd  = ^bus.writedata[31:CNT_W];

  // An abort landing on the last pulse clock suppresses DONE.
  assign done_set = !abort &&
                    ((state == IDLE && wr_pulse && mask == '0) ||
                     (state == PULSE && phase_last && pending == '0));

  // Next pulse vector feeds out_port directly so a line rises on the SCAN edge.
  always_comb begin
    pulse_nxt = pulse_vec;
    if (abort)
      pulse_nxt = '0;
    else if (state == SCAN)
      pulse_nxt = low_oh;
    else if (state == PULSE && phase_last)
      pulse_nxt = '0;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0: rd_mux[NUM_LINES-1:0] = level_q;
      3'd2: rd_mux[CNT_W-1:0]     = width_q;
      3'd3: rd_mux[CNT_W-1:0]     = gap_q;
      3'd4: rd_mux[CNT_W-1:0]     = prescale_q;
      3'd5: begin
        rd_mux[0]             = (state != IDLE);
        rd_mux[1]             = done;
        rd_mux[2]             = overrun;
        rd_mux[8 +: NUM_LINES] = pending;
      end
      3'd6: rd_mux[0] = irq_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      level_q      <= '0;
      pulse_vec    <= '0;
      pending      <= '0;
      width_q      <= '0;
      gap_q        <= '0;
      prescale_q   <= '0;
      pre_cnt      <= '0;
      pre_val      <= '0;
      phase_cnt    <= '0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      irq_en       <= 1'b0;
      out_port     <= '0;
      irq          <= 1'b0;
      bus.readdata <= '0;
    end else begin
      level_q   <= level_nxt;
      pulse_vec <= pulse_nxt;
      out_port  <= level_nxt | pulse_nxt;
      irq       <= done & irq_en;

      if (wr) begin
        case (bus.address)
          3'd2: width_q    <= bus.writedata[CNT_W-1:0];
          3'd3: gap_q      <= bus.writedata[CNT_W-1:0];
          3'd4: prescale_q <= bus.writedata[CNT_W-1:0];
          3'd6: irq_en     <= bus.writedata[0];
          default: ;
        endcase
      end

      if (done_set)
        done <= 1'b1;
      else if (done_clr)
        done <= 1'b0;

      if (wr_pulse && state != IDLE)
        overrun <= 1'b1;
      else if (wr_status && bus.writedata[2])
        overrun <= 1'b0;

      if (rd)
        bus.readdata <= rd_mux;

      // pre_val holds the prescale captured at phase entry so mid-phase writes wait for the next phase.
      if (abort) begin
        state   <= IDLE;
        pending <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (wr_pulse && mask != '0) begin
              pending <= mask;
              state   <= SCAN;
            end
          end
          SCAN: begin
            pending   <= pending & ~low_oh;
            pre_cnt   <= prescale_q;
            pre_val   <= prescale_q;
            phase_cnt <= (width_q == '0) ? CNT_W'(1) : width_q;
            state     <= PULSE;
          end
          PULSE: begin
            if (!tick_end) begin
              pre_cnt <= pre_cnt - CNT_W'(1);
            end else if (phase_cnt != CNT_W'(1)) begin
              phase_cnt <= phase_cnt - CNT_W'(1);
              pre_cnt   <= pre_val;
            end else if (pending == '0) begin
              state <= IDLE;
            end else if (gap_q != '0) begin
              pre_cnt   <= prescale_q;
              pre_val   <= prescale_q;
              phase_cnt <= gap_q;
              state     <= GAP;
            end else begin
              state <= SCAN;
            end
          end
          GAP: begin
            if (!tick_end) begin
              pre_cnt <= pre_cnt - CNT_W'(1);
            end else if (phase_cnt != CNT_W'(1)) begin
              phase_cnt <= phase_cnt - CNT_W'(1);
              pre_cnt   <= pre_val;
            end else begin
              state <= SCAN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cont_int_pulse_sequencer.sv
// Bench for cont_int_pulse_sequencer: expected readdata and per-cycle {irq,out_port} are queued, then drained against the DUT.
module tb_cont_int_pulse_sequencer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] out_port;
  logic       irq;
  int         total = 0;
  int         bad   = 0;
  logic [31:0] exp_q[$];

  cont_int_pulse_sequencer_if bus();

  cont_int_pulse_sequencer #(.NUM_LINES(6), .CNT_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
  endtask

  // Called at a negedge; the write is captured by the following posedge and returns at the next negedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    @(negedge clk);
    bus_idle();
    d = bus.readdata;
  endtask

  task automatic push_n(input logic [31:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    reset_n = 1'b0;
    bus_idle();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({irq, out_port} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=00", {irq, out_port});
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      exp_q.push_back(32'd0);
      rd(3'(a), got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, got, exp);
      end
    end
  endtask

  task automatic test_regs();
    logic [2:0]  ta [9] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd6, 3'd7, 3'd1, 3'd5};
    logic [31:0] td [9] = '{32'hFFFF_FFFF, 32'hABCD_1234, 32'hFFFF_0055, 32'h0001_0007,
                            32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] te [9] = '{32'h3F, 32'h1234, 32'h55, 32'h7, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0};
    logic [31:0] got, exp;
    for (int i = 0; i < 9; i++) begin
      // PULSE and STATUS are only read here so no sequence starts.
      if (i < 7) wr(ta[i], td[i]);
      if (i == 0) begin
        total++;
        if (out_port !== 6'h3F) begin
          bad++;
          $display("FAIL level_next_edge got=%h exp=3f", out_port);
        end
      end
      exp_q.push_back(te[i]);
      rd(ta[i], got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reg_readback addr=%0d got=%h exp=%h", ta[i], got, exp);
      end
    end
    wr(3'd0, 32'h0);
    wr(3'd6, 32'h0);
  endtask

  task automatic test_sequence();
    logic [31:0] got, exp;
    int n = 0;
    wr(3'd0, 32'h05);
    wr(3'd4, 32'd0);
    wr(3'd3, 32'd2);
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h0A);
    push_n(32'h05, 1); push_n(32'h07, 3); push_n(32'h05, 3);
    push_n(32'h0D, 3); push_n(32'h05, 2);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {25'd0, irq, out_port};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL seq_wave cyc=%0d got=%h exp=%h", n, got, exp);
      end
      n++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    exp_q.push_back(32'h2);
    rd(3'd5, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL seq_status got=%h exp=%h", got, exp);
    end
    wr(3'd5, 32'h2);
  endtask

  task automatic test_irq();
    logic [31:0] got, exp;
    int n = 0;
    wr(3'd0, 32'h0);
    wr(3'd6, 32'h1);
    wr(3'd4, 32'd4);
    wr(3'd2, 32'd2);
    wr(3'd3, 32'd0);
    wr(3'd1, 32'h21);
    push_n(32'h00, 1); push_n(32'h01, 10); push_n(32'h00, 1);
    push_n(32'h20, 10); push_n(32'h00, 1); push_n(32'h40, 2);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {25'd0, irq, out_port};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL irq_wave cyc=%0d got=%h exp=%h", n, got, exp);
      end
      n++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    wr(3'd5, 32'h2);
    push_n(32'h40, 1); push_n(32'h00, 1);
    n = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {25'd0, irq, out_port};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL irq_clear cyc=%0d got=%h exp=%h", n, got, exp);
      end
      n++;
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_overrun_abort();
    logic [31:0] got, exp;
    int n = 0;
    wr(3'd0, 32'h08);
    wr(3'd4, 32'd0);
    wr(3'd2, 32'd4);
    wr(3'd3, 32'd1);
    wr(3'd1, 32'h3F);
    wr(3'd1, 32'h01);
    push_n(32'h09, 4); push_n(32'h08, 2); push_n(32'h0A, 4);
    push_n(32'h08, 2); push_n(32'h0C, 1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {25'd0, irq, out_port};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL overrun_wave cyc=%0d got=%h exp=%h", n, got, exp);
      end
      n++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    wr(3'd5, 32'h8);
    total++;
    if ({irq, out_port} !== 7'h08) begin
      bad++;
      $display("FAIL abort_out got=%h exp=08", {irq, out_port});
    end
    exp_q.push_back(32'h4);
    rd(3'd5, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL abort_status got=%h exp=%h", got, exp);
    end
    wr(3'd5, 32'h4);
    exp_q.push_back(32'h0);
    rd(3'd5, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL overrun_clear got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_min_width();
    logic [31:0] got, exp;
    int n = 0;
    wr(3'd0, 32'h0);
    wr(3'd2, 32'd0);
    wr(3'd4, 32'd2);
    wr(3'd3, 32'd0);
    wr(3'd1, 32'h10);
    push_n(32'h00, 1); push_n(32'h10, 3); push_n(32'h00, 1); push_n(32'h40, 2);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {25'd0, irq, out_port};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL minw_wave cyc=%0d got=%h exp=%h", n, got, exp);
      end
      n++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    wr(3'd5, 32'h2);
    @(negedge clk);
    wr(3'd1, 32'h0);
    push_n(32'h00, 1); push_n(32'h40, 1);
    n = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {25'd0, irq, out_port};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL zero_mask_wave cyc=%0d got=%h exp=%h", n, got, exp);
      end
      n++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    exp_q.push_back(32'h2);
    rd(3'd5, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL zero_mask_status got=%h exp=%h", got, exp);
    end
    wr(3'd5, 32'h2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    int n = 0;
    wr(3'd6, 32'h0);
    wr(3'd0, 32'h02);
    wr(3'd4, 32'd0);
    wr(3'd2, 32'd8);
    wr(3'd1, 32'h01);
    @(negedge clk);
    total++;
    if (out_port !== 6'h03) begin
      bad++;
      $display("FAIL mid_pulse_out got=%h exp=03", out_port);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({irq, out_port} !== 7'h00) begin
      bad++;
      $display("FAIL async_reset_out got=%h exp=00", {irq, out_port});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0);
    rd(3'd5, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL post_reset_status got=%h exp=%h", got, exp);
    end
    wr(3'd1, 32'h04);
    push_n(32'h00, 1); push_n(32'h04, 1); push_n(32'h00, 2);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {25'd0, irq, out_port};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL post_reset_wave cyc=%0d got=%h exp=%h", n, got, exp);
      end
      n++;
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_sequence();
    test_irq();
    test_overrun_abort();
    test_min_width();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
